// File: rtl/assoc_cache_pkg.sv
// Shared types for the LC-3b set-associative cache: line/word types, FSM states,
// line geometry and the byte-lane merge helper.
package assoc_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } lc3b_cache_state;

  localparam int LINE_OFFSET_BITS = 4;

  // Overwrite only the enabled byte lanes of one 16-bit word inside a line.
  function automatic lc3b_cache_line merge_word(input lc3b_cache_line line,
                                                input logic [2:0]     word,
                                                input lc3b_word       data,
                                                input lc3b_mem_wmask  mask);
    lc3b_cache_line merged;
    merged = line;
    if (mask[0]) merged[{word, 4'b0000} +: 8] = data[7:0];
    if (mask[1]) merged[{word, 4'b1000} +: 8] = data[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/assoc_cache_plru.sv
// Tree pseudo-LRU bookkeeping: WAYS-1 bits per set. A bit of 1 means the
// colder (victim-side) half below that node is the upper-index half.
module cache_plru
  import assoc_cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  localparam int IDX_BITS = $clog2(SETS),
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] index,
  input  logic                touch,
  input  logic [WAY_BITS-1:0] touch_way,
  output logic [WAY_BITS-1:0] victim_way
);

  if (WAYS == 1) begin : g_direct
    assign victim_way = '0;
  end else begin : g_tree
    localparam int LEVELS = $clog2(WAYS);

    logic [SETS-1:0][WAYS-2:0] tree_q;
    logic [WAYS-2:0]           cur;
    logic [WAYS-2:0]           nxt;
    logic [WAY_BITS-1:0]       victim;
    int                        node_t;
    int                        node_v;

    // Heap-ordered tree: children of node n are 2n+1 (lower half) and 2n+2.
    always_comb begin
      // NOTE: every variable gets a default before any conditional/loop so no latch is inferred.
      cur    = tree_q[index];
      nxt    = cur;
      victim = '0;
      node_t = 0;
      node_v = 0;
      for (int l = 0; l < LEVELS; l++) begin
        nxt[node_t]         = ~touch_way[LEVELS-1-l];
        node_t              = 2 * node_t + 1 + int'(touch_way[LEVELS-1-l]);
        victim[LEVELS-1-l]  = cur[node_v];
        node_v              = 2 * node_v + 1 + int'(cur[node_v]);
      end
    end

    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments; blocking is reserved for always_comb temporaries.
      if (reset) begin
        tree_q <= '0;
      end else if (touch) begin
        tree_q[index] <= nxt;
      end
    end

    assign victim_way = victim;
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate cache between the LC-3b memory
// stage and physical memory. Optional hit/miss counters: ASSOC_CACHE_PERF_EN.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp,
  output logic [15:0]  pmem_address,
  input  logic [127:0] pmem_rdata,
  output logic [127:0] pmem_wdata
`ifdef ASSOC_CACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 16 - LINE_OFFSET_BITS - IDX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic [2:0]          word;
  logic                unused_byte_bit;

  assign idx             = mem_address[LINE_OFFSET_BITS +: IDX_BITS];
  assign tag             = mem_address[15 -: TAG_BITS];
  assign word            = mem_address[3:1];
  assign unused_byte_bit = mem_address[0];

  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [WAYS-1:0][SETS-1:0] dirty_q;
  logic [TAG_BITS-1:0]       tag_q  [WAYS][SETS];
  lc3b_cache_line            line_q [WAYS][SETS];

  lc3b_cache_state state_q, state_d;
  logic [WAY_BITS-1:0] victim_q;

  logic                req;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] plru_victim;
  logic [WAY_BITS-1:0] victim_sel;
  logic                plru_touch;
  logic                latch_victim;
  logic                write_hit;
  logic                wb_done;
  logic                fill_done;

  assign req = mem_read | mem_write;

  // Tag lookup and lowest-index invalid way for the addressed set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!inv_found && !valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  assign victim_sel = inv_found ? inv_way : plru_victim;
  assign mem_rdata  = line_q[hit_way][idx][{word, 4'b0000} +: 16];

  cache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk        (clk),
    .reset      (reset),
    .index      (idx),
    .touch      (plru_touch),
    .touch_way  (hit_way),
    .victim_way (plru_victim)
  );

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    plru_touch   = 1'b0;
    latch_victim = 1'b0;
    write_hit    = 1'b0;
    wb_done      = 1'b0;
    fill_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp   = 1'b1;
            plru_touch = 1'b1;
            write_hit  = mem_write;
          end else begin
            latch_victim = 1'b1;
            state_d = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][idx], idx, 4'b0000};
        pmem_wdata   = line_q[victim_q][idx];
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_victim) victim_q <= victim_sel;
      if (write_hit) dirty_q[hit_way][idx] <= 1'b1;
      if (wb_done) dirty_q[victim_q][idx] <= 1'b0;
      if (fill_done) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and line arrays are not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      line_q[hit_way][idx] <= merge_word(line_q[hit_way][idx], word, mem_wdata, mem_byte_enable);
    end
    if (fill_done) begin
      line_q[victim_q][idx] <= pmem_rdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end

`ifdef ASSOC_CACHE_PERF_EN
  // A request is a miss if it ever left IDLE before its completion pulse.
  logic missed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      missed_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (latch_victim) missed_q <= 1'b1;
      if (mem_resp) begin
        missed_q <= 1'b0;
        if (missed_q) begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end else begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule
